// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state enum and sizing helpers for the systolic matrix-multiply engine
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED,
        CAPTURE
    } state_e;

    function automatic int acc_width(input int dw, input int size);
        return 2 * dw + $clog2(size);
    endfunction

    function automatic int feed_cycles(input int q, input int r, input int k);
        return q + r + k - 1;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - output-stationary processing element: forwards a right and b down, accumulates a*b
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 34
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [DW-1:0] b_in,
    output logic signed [DW-1:0] a_out,
    output logic signed [DW-1:0] b_out,
    output logic signed [AW-1:0] acc
);

    logic signed [DW-1:0]   a_q, b_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [2*DW-1:0] prod;

    // The full signed product always fits in 2*DW bits, so truncating the widened product is exact.
    assign prod = (2*DW)'(a_in) * (2*DW)'(b_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (clear) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en) begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_q + AW'(prod);
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - SIZExSIZE systolic C=AxB engine with row buffers and skew feeder
// Build option: define SYSTOLIC_SAT_EN to saturate dout elements instead of wrapping.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int SIZE      = 4,
    parameter int DIMW      = $clog2(SIZE) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DIMW-1:0]                depth_A,
    input  logic [DIMW-1:0]                width_A,
    input  logic [DIMW-1:0]                depth_B,
    input  logic [DIMW-1:0]                width_B,
    input  logic                           wen,
    input  logic                           wsel,
    input  logic [$clog2(SIZE)-1:0]        waddr,
    input  logic [SIZE*DATAWIDTH-1:0]      wdata,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [SIZE*SIZE*DATAWIDTH-1:0] dout
);

    localparam int AW = acc_width(DATAWIDTH, SIZE);
    localparam int IW = $clog2(SIZE);
    localparam int TW = $clog2(3 * SIZE);
    localparam logic signed [AW-1:0] ACC_MAX = {{(AW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(AW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

    state_e                          state_q, state_d;
    logic [TW-1:0]                   t_q, t_d;
    logic [DIMW-1:0]                 q_q, r_q, k_q;
    logic                            done_q, err_q;
    logic [SIZE*SIZE*DATAWIDTH-1:0]  dout_q, dout_d;
    logic [SIZE*DATAWIDTH-1:0]       a_buf_q [SIZE];
    logic [SIZE*DATAWIDTH-1:0]       b_buf_q [SIZE];

    logic signed [DATAWIDTH-1:0]     a_h [SIZE][SIZE+1];
    logic signed [DATAWIDTH-1:0]     b_v [SIZE+1][SIZE];
    logic signed [AW-1:0]            acc [SIZE][SIZE];

    logic dims_ok, start_ok, last_step, pe_clear, pe_en;

    assign dims_ok = (depth_A != '0) && (depth_A <= DIMW'(SIZE)) &&
                     (width_A != '0) && (width_A <= DIMW'(SIZE)) &&
                     (width_B != '0) && (width_B <= DIMW'(SIZE)) &&
                     (depth_B == width_A);
    assign start_ok  = (state_q == IDLE) && start && dims_ok;
    assign last_step = (int'(t_q) == feed_cycles(int'(q_q), int'(r_q), int'(k_q)) - 1);
    assign pe_clear  = (state_q == CLEAR);
    assign pe_en     = (state_q == FEED) || (state_q == CAPTURE);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = CLEAR;
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
            end
            FEED: begin
                if (last_step) begin
                    state_d = CAPTURE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            done_q  <= (state_q == CAPTURE);
            err_q   <= (state_q == IDLE) && start && !dims_ok;
            if (start_ok) begin
                q_q <= depth_A;
                r_q <= width_A;
                k_q <= width_B;
            end
            if (state_q == CAPTURE) dout_q <= dout_d;
        end
    end

    // A write coinciding with an accepted start lands before FEED reads the buffers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_buf_q <= '{default: '0};
            b_buf_q <= '{default: '0};
        end else if (wen && (state_q == IDLE)) begin
            if (wsel) b_buf_q[waddr] <= wdata;
            else      a_buf_q[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_feed_a
        logic signed [DATAWIDTH-1:0] a_feed;
        always_comb begin
            int ia;
            ia     = int'(t_q) - i;
            a_feed = '0;
            if ((state_q == FEED) && (i < int'(q_q)) && (ia >= 0) && (ia < int'(r_q)))
                a_feed = a_buf_q[i][ia[IW-1:0]*DATAWIDTH +: DATAWIDTH];
        end
        assign a_h[i][0] = a_feed;
    end

    for (genvar j = 0; j < SIZE; j++) begin : g_feed_b
        logic signed [DATAWIDTH-1:0] b_feed;
        always_comb begin
            int ib;
            ib     = int'(t_q) - j;
            b_feed = '0;
            if ((state_q == FEED) && (j < int'(k_q)) && (ib >= 0) && (ib < int'(r_q)))
                b_feed = b_buf_q[ib[IW-1:0]][j*DATAWIDTH +: DATAWIDTH];
        end
        assign b_v[0][j] = b_feed;
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            systolic_pe #(
                .DW(DATAWIDTH),
                .AW(AW)
            ) u_pe (
                .clk  (clk),
                .reset(reset),
                .clear(pe_clear),
                .en   (pe_en),
                .a_in (a_h[i][j]),
                .b_in (b_v[i][j]),
                .a_out(a_h[i][j+1]),
                .b_out(b_v[i+1][j]),
                .acc  (acc[i][j])
            );
`ifdef SYSTOLIC_SAT_EN
            assign dout_d[(i*SIZE+j)*DATAWIDTH +: DATAWIDTH] =
                (acc[i][j] > ACC_MAX) ? {1'b0, {(DATAWIDTH-1){1'b1}}} :
                (acc[i][j] < ACC_MIN) ? {1'b1, {(DATAWIDTH-1){1'b0}}} :
                                        acc[i][j][DATAWIDTH-1:0];
`else
            assign dout_d[(i*SIZE+j)*DATAWIDTH +: DATAWIDTH] = acc[i][j][DATAWIDTH-1:0];
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;
    assign dout = dout_q;

endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parametrised matrix-multiply engine computing C = A×B for A (Q×R) and B (R×K), with Q, R, K ≤ SIZE, on a SIZE×SIZE output-stationary systolic array. It generalises the fixed 16-bit 4×4 accelerator top. Operands are held in internal row buffers instead of SIZE² input ports per matrix. A counter-driven skew feeder, a start/busy/done/err handshake, and a registered result bank are included. It sits between the host register/DMA interface and downstream result consumers.

## Interface
- DATAWIDTH, 16, operand and result element width (signed two's complement)
- SIZE, 4, array dimension; maximum Q, R, K
- DIMW, $clog2(SIZE)+1, dimension port width (derived; do not override)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- depth_A, width_A, depth_B, width_B  in  DIMW each  Q, R, R', K; sampled with start
- wen  in  1  row write strobe
- wsel  in  1  0 = A buffer, 1 = B buffer
- waddr  in  $clog2(SIZE)  row index
- wdata  in  SIZE*DATAWIDTH  row; element c at [c*DATAWIDTH +: DATAWIDTH]
- start  in  1  launch request
- busy  out  1  computation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejected-start pulse
- dout  out  SIZE*SIZE*DATAWIDTH  result; C[i][j] at [(i*SIZE+j)*DATAWIDTH +: DATAWIDTH]

## Operation
- FSM states: IDLE, CLEAR, FEED, CAPTURE.
  - IDLE→CLEAR on a valid start.
  - CLEAR: 1 cycle; all accumulators and PE pipeline registers are zeroed.
  - FEED: step counter t runs 0..Q+R+K-2 (Q+R+K-1 cycles).
  - CAPTURE: 1 cycle. On its exit edge, the accumulators are copied to dout, done is set, and the FSM returns to IDLE.
- Valid start requires 1≤Q,R,K≤SIZE and depth_B==width_A. Otherwise:
  - err pulses the next cycle.
  - The FSM stays in IDLE.
  - dout is unchanged.
- Dimensions are latched at start. Later changes to the dimension inputs have no effect on the computation in progress.
- Feed at step t:
  - Row input i = A[i][t-i] if i<Q and 0≤t-i<R, else 0.
  - Column input j = B[t-j][j] if j<K and 0≤t-j<R, else 0.
- PEs forward A right and B down through one register each.
- Each PE computes acc += a×b on every FEED and CAPTURE cycle.
- Entries with i≥Q or j≥K read 0.
- Product is full 2·DATAWIDTH signed. The accumulator is 2·DATAWIDTH+$clog2(SIZE) bits, so it cannot overflow.
- dout element = accumulator reduced to DATAWIDTH (see Configuration).
- Writes:
  - Accepted only in IDLE; wen is ignored while busy.
  - A write in the same cycle as an accepted start is committed and is used by that computation.
- start while busy: ignored, no err.

## Timing
- Reset values: busy=0, done=0, err=0, dout=0, both buffers=0, FSM=IDLE, t=0.
- Reset mid-operation aborts the computation immediately, with no done pulse.
- Edge 0 samples start. busy is high in cycles 1..Q+R+K+1.
- done and valid dout appear in cycle Q+R+K+2, with busy=0 in that cycle.
- A new start is accepted in the done cycle.
- dout holds its value until the next done.
- err appears in cycle 1 after a rejected start; busy stays 0.

## Configuration
- SYSTOLIC_SAT_EN defined: dout elements saturate to the signed DATAWIDTH range [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1].
- SYSTOLIC_SAT_EN undefined: dout elements are the low DATAWIDTH bits of the accumulator (wrap).

## Structure
- Package systolic_pkg holds:
  - the state enum (IDLE, CLEAR, FEED, CAPTURE);
  - the accumulator-width function;
  - a function for the cycle count Q+R+K-1.
- One sub-module, systolic_pe: a_in/b_in → registered a_out/b_out, plus clear, en and the accumulator.
- The PE array is instantiated with a generate loop.

## Test plan
- Identity (SIZE=4): A=I4, B[i][j]=4i+j+1, Q=R=K=4 → dout = B; done at cycle 14; busy high in cycles 1..13.
- Rectangular case: Q=2, R=3, K=2, A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]] → C=[[58,64],[139,154]], all other elements 0; done at cycle 9.
- Saturation: 1×1×1 with A=B=300.
  - Macro defined → 32767.
  - Macro undefined → 90000 mod 2^16 = 24464.
  - Both cases: done at cycle 5.
- Errors: width_A=3 with depth_B=2, and separately Q=0 → err pulse at cycle 1, busy stays 0, dout unchanged.
- Reset in cycle 6 of a 4×4×4 run → all outputs 0, no done. A subsequent run completes correctly.
- Back-to-back: start asserted in the done cycle, plus a wen while busy → second result correct and unaffected by the ignored write.
